// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file access controller.
// Holds the default widths, the opcode encodings, the controller state
// encoding and the bit positions of the instruction fields. The package
// also provides small opcode classification helpers.
package rf_ctrl_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 2;
  localparam int OP_W       = 4;

  // Instruction field positions: op[9:6] rd[5:4] rs[3:2] rt[1:0]
  localparam int OP_LSB = 6;
  localparam int RD_LSB = 4;
  localparam int RS_LSB = 2;
  localparam int RT_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND = 4'b0011;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0101;
  localparam logic [OP_W-1:0] OP_MOV = 4'b0110;
  localparam logic [OP_W-1:0] OP_LDI = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  // Any opcode with the top bit set is undefined.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

  // ADD..LDI produce a value that is written back.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return !op[OP_W-1] && (op != OP_NOP);
  endfunction

  // Only the arithmetic/logic group touches the flags.
  function automatic logic op_sets_flags(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/rf_access_ctrl_alu10.sv
// alu10: combinational execution unit of the register-file controller.
// Ports:
//   op     - opcode of the latched instruction
//   opa    - first source operand (register rs)
//   opb    - second source operand (register rt)
//   imm    - latched immediate, used by LDI
//   result - operation result, unsigned modulo 2^DATA_W (0 for NOP/illegal)
//   carry  - carry-out for ADD, borrow (opa<opb) for SUB, 0 otherwise
//   zero   - result equals zero
module alu10
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, opa} + {1'b0, opb};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        sum    = {1'b0, opa} - {1'b0, opb};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_XOR:  result = opa ^ opb;
      OP_MOV:  result = opa;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: four-state controller that reads two registers, executes
// one ALU operation and writes the result back to an external register file.
// Sequence per instruction: IDLE -> READ -> EXEC -> WRITE -> IDLE.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   instr_valid/instr_ready - instruction handshake (ready only in IDLE)
//   instr, imm              - instruction word and LDI immediate
//   rf_rae/rf_raa           - read port A enable/address (rs)
//   rf_rbe/rf_rba           - read port B enable/address (rt)
//   rf_aout/rf_bout         - asynchronous read data from the register file
//   rf_we/rf_wa/rf_wdata    - write port toward the register file
//   done, err               - retire pulse, illegal-opcode pulse
//   flag_z, flag_c          - zero flag, carry/borrow flag
// All outputs are decoded from the state register and latched fields, so an
// asserted rst_n drops every enable without waiting for a clock edge.
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] imm,
  output logic              rf_rae,
  output logic [ADDR_W-1:0] rf_raa,
  output logic              rf_rbe,
  output logic [ADDR_W-1:0] rf_rba,
  input  logic [DATA_W-1:0] rf_aout,
  input  logic [DATA_W-1:0] rf_bout,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] instr_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0] opa_p1;
  logic [DATA_W-1:0] opb_p1;
  logic [DATA_W-1:0] result_p2;

  logic [OP_W-1:0]   op_p0;
  logic [ADDR_W-1:0] rd_p0;
  logic [ADDR_W-1:0] rs_p0;
  logic [ADDR_W-1:0] rt_p0;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  assign op_p0 = instr_p0[OP_LSB +: OP_W];
  assign rd_p0 = instr_p0[RD_LSB +: ADDR_W];
  assign rs_p0 = instr_p0[RS_LSB +: ADDR_W];
  assign rt_p0 = instr_p0[RT_LSB +: ADDR_W];

  alu10 #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_p0),
    .opa    (opa_p1),
    .opb    (opb_p1),
    .imm    (imm_p0),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p0  <= '0;
      imm_p0    <= '0;
      opa_p1    <= '0;
      opb_p1    <= '0;
      result_p2 <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
    end else begin
      // Stage p0: latch the accepted instruction and immediate
      if ((state_q == IDLE) && instr_valid) begin
        instr_p0 <= instr;
        imm_p0   <= imm;
      end
      // Stage p1: capture register-file read data at the end of READ
      if (state_q == READ) begin
        opa_p1 <= rf_aout;
        opb_p1 <= rf_bout;
      end
      // Stage p2: register the ALU result and, for ADD..XOR, the flags
      if (state_q == EXEC) begin
        result_p2 <= alu_result;
        if (op_sets_flags(op_p0)) begin
          flag_z <= alu_zero;
          flag_c <= alu_carry;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_rae      = 1'b0;
    rf_raa      = '0;
    rf_rbe      = 1'b0;
    rf_rba      = '0;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = READ;
      end
      READ: begin
        rf_rae  = 1'b1;
        rf_raa  = rs_p0;
        rf_rbe  = 1'b1;
        rf_rba  = rt_p0;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = WRITE;
      end
      WRITE: begin
        rf_we    = op_writes(op_p0);
        rf_wa    = rd_p0;
        rf_wdata = result_p2;
        done     = 1'b1;
        err      = op_illegal(op_p0);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
module tb_rf_access_ctrl;
  import rf_ctrl_pkg::*;

  localparam int DW = 10;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [DW-1:0] imm;
  logic          rf_rae, rf_rbe, rf_we;
  logic [AW-1:0] rf_raa, rf_rba, rf_wa;
  logic [DW-1:0] rf_aout, rf_bout, rf_wdata;
  logic          done, err, flag_z, flag_c;

  always #5 clk = ~clk;

  rf_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .imm         (imm),
    .rf_rae      (rf_rae),
    .rf_raa      (rf_raa),
    .rf_rbe      (rf_rbe),
    .rf_rba      (rf_rba),
    .rf_aout     (rf_aout),
    .rf_bout     (rf_bout),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wdata    (rf_wdata),
    .done        (done),
    .err         (err),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  // 4x10-bit register file: asynchronous reads, synchronous write
  logic [DW-1:0] regs [4];
  always @(posedge clk) if (rf_we) regs[rf_wa] <= rf_wdata;
  assign rf_aout = rf_rae ? regs[rf_raa] : '0;
  assign rf_bout = rf_rbe ? regs[rf_rba] : '0;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          err;
    logic          z;
    logic          c;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mregs [4];
  logic          mz, mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every retirement is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rf_we && !done) chk("we_without_done", 32'(rf_we), 32'd0);
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rf_we", 32'(rf_we), 32'(e.we));
        chk("rf_wa", 32'(rf_wa), 32'(e.wa));
        if (e.we) chk("rf_wdata", 32'(rf_wdata), 32'(e.wd));
        chk("err", 32'(err), 32'(e.err));
        chk("flag_z", 32'(flag_z), 32'(e.z));
        chk("flag_c", 32'(flag_c), 32'(e.c));
      end
    end
  end

  // Offers one instruction (instr_valid left high) and follows it to IDLE
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [DW-1:0] im, input logic ewe,
                       input logic [DW-1:0] ewd, input logic eerr, input logic ez,
                       input logic ec);
    exp_t e;
    int n;
    e.we = ewe; e.wa = rd; e.wd = ewd; e.err = eerr; e.z = ez; e.c = ec;
    sb.push_back(e);
    instr_valid = 1'b1;
    instr       = {op, rd, rs, rt};
    imm         = im;
    n = 0;
    while (!instr_ready && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_idle", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    chk("ready_read", 32'(instr_ready), 32'd0);
    chk("rae", 32'(rf_rae), 32'd1);
    chk("raa", 32'(rf_raa), 32'(rs));
    chk("rbe", 32'(rf_rbe), 32'd1);
    chk("rba", 32'(rf_rba), 32'(rt));
    @(posedge clk); #1;
    chk("ready_exec", 32'(instr_ready), 32'd0);
    chk("rae_exec", 32'(rf_rae), 32'd0);
    @(posedge clk); #1;
    chk("ready_write", 32'(instr_ready), 32'd0);
    chk("we_n3", 32'(rf_we), 32'(ewe));
    @(posedge clk); #1;
    chk("ready_n4", 32'(instr_ready), 32'd1);
    if (ewe) mregs[rd] = ewd;
    mz = ez;
    mc = ec;
  endtask

  task automatic rand_one();
    logic [3:0]    op;
    logic [1:0]    rd, rs, rt;
    logic [DW-1:0] im, a, b, r;
    logic [DW:0]   s;
    logic          we, er, z, c;
    op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 7));
    rd = 2'($urandom); rs = 2'($urandom); rt = 2'($urandom);
    im = 10'($urandom);
    a = mregs[rs]; b = mregs[rt];
    r = '0; z = mz; c = mc;
    we = (op >= 4'd1) && (op <= 4'd7);
    er = (op >= 4'd8);
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[DW-1:0]; c = s[DW]; z = (r == 0); end
      4'd2: begin r = a - b; c = (a < b); z = (r == 0); end
      4'd3: begin r = a & b; c = 1'b0; z = (r == 0); end
      4'd4: begin r = a | b; c = 1'b0; z = (r == 0); end
      4'd5: begin r = a ^ b; c = 1'b0; z = (r == 0); end
      4'd6: r = a;
      4'd7: r = im;
      default: r = '0;
    endcase
    issue(op, rd, rs, rt, im, we, r, er, z, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; imm = '0;
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    mz = 1'b0; mc = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_rae", 32'(rf_rae), 32'd0);
    chk("rst_rbe", 32'(rf_rbe), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_flag_z", 32'(flag_z), 32'd0);
    chk("rst_flag_c", 32'(flag_c), 32'd0);
    rst_n = 1'b1;

    // LDI r1,0x3FF ; LDI r2,0x001 ; ADD r3=r1+r2 -> 0x000, c=1 z=1
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 10'h3FF, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0);
    issue(OP_LDI, 2'd2, 2'd0, 2'd0, 10'h001, 1'b1, 10'h001, 1'b0, 1'b0, 1'b0);
    issue(OP_ADD, 2'd3, 2'd1, 2'd2, 10'h000, 1'b1, 10'h000, 1'b0, 1'b1, 1'b1);
    chk("r3_after_add", 32'(regs[3]), 32'h000);
    // SUB r0=r2-r1 = 0x001-0x3FF -> 0x002, borrow
    issue(OP_SUB, 2'd0, 2'd2, 2'd1, 10'h000, 1'b1, 10'h002, 1'b0, 1'b0, 1'b1);
    chk("r0_after_sub", 32'(regs[0]), 32'h002);
    // Back-to-back: XOR r3=r1^r0 = 0x3FD, then MOV r2=r3 reads fresh 0x3FD
    issue(OP_XOR, 2'd3, 2'd1, 2'd0, 10'h000, 1'b1, 10'h3FD, 1'b0, 1'b0, 1'b0);
    issue(OP_MOV, 2'd2, 2'd3, 2'd0, 10'h000, 1'b1, 10'h3FD, 1'b0, 1'b0, 1'b0);
    chk("r2_after_mov", 32'(regs[2]), 32'h3FD);
    // ADD r0=r1+r0 -> 0x001 c=1, then illegal 1010 and NOP keep flags
    issue(OP_ADD, 2'd0, 2'd1, 2'd0, 10'h000, 1'b1, 10'h001, 1'b0, 1'b0, 1'b1);
    issue(4'b1010, 2'd1, 2'd2, 2'd3, 10'h155, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1);
    issue(OP_NOP, 2'd1, 2'd2, 2'd3, 10'h155, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("r1_after_illegal", 32'(regs[1]), 32'h3FF);
    instr_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("idle_hold_ready", 32'(instr_ready), 32'd1);
    chk("idle_hold_rae", 32'(rf_rae), 32'd0);

    // ADD r1=r2+r3 abandoned by reset during WRITE
    instr_valid = 1'b1;
    instr = {OP_ADD, 2'd1, 2'd2, 2'd3};
    imm = '0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("abort_we_before", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_drop", 32'(rf_we), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flag_c", 32'(flag_c), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mz = 1'b0; mc = 1'b0;
    chk("abort_r1_kept", 32'(regs[1]), 32'h3FF);
    @(posedge clk); #1;
    chk("abort_ready_after", 32'(instr_ready), 32'd1);

    for (int i = 0; i < 10000; i++) begin
      rand_one();
      if ($urandom_range(0, 7) == 0) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    instr_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk("final_reg", 32'(regs[i]), 32'(mregs[i]));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_access_ctrl.md
RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 10: datapath and register width.
REQ-002 Parameter ADDR_W, default 2: register-file address width, giving 4 registers.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port instr_valid, input, 1: instruction offered.
REQ-006 Port instr_ready, output, 1: controller can accept an instruction.
REQ-007 Port instr, input, DATA_W: instruction fields.
  - op = instr[9:6]
  - rd = instr[5:4]
  - rs = instr[3:2]
  - rt = instr[1:0]
REQ-008 Port imm, input, DATA_W: immediate for LDI, sampled with instr.
REQ-009 Port rf_rae/rf_raa, output, 1/ADDR_W: read port A enable and address toward the register file.
REQ-010 Port rf_rbe/rf_rba, output, 1/ADDR_W: read port B enable and address.
REQ-011 Port rf_aout/rf_bout, input, DATA_W each: asynchronous read data returned by the register file.
REQ-012 Port rf_we/rf_wa/rf_wdata, output, 1/ADDR_W/DATA_W: write enable, address and data.
REQ-013 Port done, output, 1: one-cycle pulse when an instruction retires.
REQ-014 Port err, output, 1: one-cycle pulse, coincident with done, for an illegal opcode.
REQ-015 Port flag_z/flag_c, output, 1 each: zero flag and carry/borrow flag.

Function
REQ-016 The controller SHALL implement the FSM IDLE -> READ -> EXEC -> WRITE -> IDLE, advancing one state per cycle with no stalls.
REQ-017 In IDLE, instr_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-018 On instr_valid&&instr_ready, the controller SHALL latch instr and imm and enter READ.
REQ-019 While instr_valid is 0, the controller SHALL remain in IDLE.
REQ-020 In READ, the controller SHALL drive:
  - rf_rae=1, rf_raa=rs
  - rf_rbe=1, rf_rba=rt
  - capture rf_aout into opa and rf_bout into opb at the end of the cycle.
REQ-021 The read enables and addresses SHALL be 0 in all other states.
REQ-022 In EXEC, the controller SHALL compute result from opa/opb and register it.
  - 0001 ADD: opa+opb
  - 0010 SUB: opa-opb
  - 0011 AND, 0100 OR, 0101 XOR: bitwise
  - 0110 MOV: opa
  - 0111 LDI: latched imm
  - 0000 NOP
  - 1000-1111: illegal
REQ-023 Arithmetic SHALL be unsigned mod 2^DATA_W.
REQ-024 flag_c SHALL be the carry-out of ADD, or the borrow (opa<opb) of SUB.
REQ-025 flag_z SHALL be (result==0).
REQ-026 Both flags SHALL update only for opcodes 0001-0101 and SHALL hold otherwise.
REQ-027 In WRITE, the controller SHALL drive rf_wa=rd and rf_wdata=result, with rf_we=1 only for opcodes 0001-0111.
REQ-028 In WRITE, NOP and illegal opcodes SHALL drive rf_we=0.
REQ-029 In WRITE, done SHALL be 1; err SHALL be 1 only for an illegal opcode.
REQ-030 Latency: an instruction accepted on edge N SHALL assert rf_we during cycle N+3, and instr_ready SHALL be 1 again in cycle N+4.
REQ-031 Read-after-write: because each write completes before the next READ, an instruction whose rs or rt equals the previous rd SHALL read the new value; no forwarding is needed.
REQ-032 rs==rt, and rd equal to either source, SHALL behave identically to distinct addresses.
REQ-033 All outputs SHALL be functions of the state register and latched fields only (Moore); rf_wdata SHALL be 0 outside WRITE.

Reset
REQ-034 Asserting rst_n low SHALL, at any time and asynchronously, force:
  - state=IDLE
  - instr_ready=1
  - rf_we=rf_rae=rf_rbe=0
  - all addresses and data 0
  - done=err=0
  - flag_z=flag_c=0
  - opa=opb=result=0
REQ-035 A reset asserted mid-instruction SHALL abandon the instruction with no register-file write, including when it is asserted during WRITE before the clock edge.
REQ-036 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising edge.

Structure
REQ-037 A shared package rf_ctrl_pkg SHALL hold:
  - DATA_W and ADDR_W defaults
  - the opcode constants
  - the state enum (IDLE, READ, EXEC, WRITE)
  - the instruction field bit positions
REQ-038 A combinational sub-module alu10 SHALL compute result, carry and zero from op, opa, opb and imm; the FSM SHALL remain in rf_access_ctrl.
REQ-039 The bench SHALL connect the controller to the team's 4x10-bit register file.

Verification
REQ-040 Scenario: reset, then LDI r1,imm=0x3FF and LDI r2,imm=0x001, then ADD r3=r1+r2.
  - r3=0x000
  - flag_c=1, flag_z=1
  - rf_we in cycle N+3 of each instruction
REQ-041 Scenario: SUB r0=r2-r1 with r2=0x001, r1=0x3FF.
  - r0=0x002
  - flag_c=1, flag_z=0
REQ-042 Scenario: back-to-back instructions with instr_valid held high; MOV r2=r3 immediately after a write to r3.
  - instr_ready pattern 1,0,0,0,1
  - MOV reads the fresh r3 value
REQ-043 Scenario: opcode 1010 and opcode 0000.
  - rf_we stays 0
  - done pulses for both
  - err pulses only for 1010
  - flags unchanged
REQ-044 Scenario: rst_n pulsed low during WRITE of ADD r1.
  - rf_we drops immediately
  - r1 retains its old value
  - instr_ready=1 after release
REQ-045 Scenario: random ops for 10k instructions checked against a reference model of the 4 registers and the flags.
